// File: rtl/run_detect_sched.sv
// Two-requester serializer that feeds words MSB-first to an external
// run detector and counts the cycles its output is high per word.
module run_detect_sched #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             w,
    output logic             det_rst_n,
    input  logic             z,
    output logic             result_valid,
    output logic [CW-1:0]    result_count,
    output logic             result_id,
    input  logic             result_ready
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_data;
    logic [BW-1:0]    r_bit;
    logic [CW-1:0]    r_cnt;
    logic             r_id;
    logic             r_last;
    logic             r_det_rst_n;

    logic w_grant;
    logic w_idle;
    logic w_take;
    logic w_last_bit;
    logic w_sample;

    // Round-robin grant: a tie goes to whoever was not served last
    always_comb begin
        w_grant = 1'b0;
        if (req1_valid && (!req0_valid || !r_last)) begin
            w_grant = 1'b1;
        end
    end

    assign w_idle     = (r_state == IDLE) && reset;
    assign req0_ready = w_idle && req0_valid && !w_grant;
    assign req1_ready = w_idle && req1_valid && w_grant;
    assign w_take     = req0_ready || req1_ready;
    assign w_last_bit = (r_bit == BW'(WIDTH - 1));
    // z lags w by one cycle, so SHIFT cycle 0 carries no information
    assign w_sample   = ((r_state == SHIFT) && (r_bit != '0))
                     || (r_state == DRAIN);

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_take) w_next = CLEAR;
            CLEAR:   w_next = SHIFT;
            SHIFT:   if (w_last_bit) w_next = DRAIN;
            DRAIN:   w_next = DONE;
            DONE:    if (result_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Detector clear pulse, registered from the upcoming state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_det_rst_n <= 1'b0;
        else        r_det_rst_n <= (w_next != CLEAR);
    end

    // Word capture, owner tag, arbitration history and MSB-first shifting
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_data <= '0;
            r_id   <= 1'b0;
            r_last <= 1'b1;
        end else if (w_take) begin
            r_data <= w_grant ? req1_data : req0_data;
            r_id   <= w_grant;
            r_last <= w_grant;
        end else if (r_state == SHIFT) begin
            r_data <= r_data << 1;
        end
    end

    // Bit index and saturating hit counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_bit <= '0;
            r_cnt <= '0;
        end else if (r_state == CLEAR) begin
            r_bit <= '0;
            r_cnt <= '0;
        end else begin
            if (r_state == SHIFT) r_bit <= r_bit + 1'b1;
            if (w_sample && z && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w            = (r_state == SHIFT) && r_data[WIDTH-1];
    assign det_rst_n    = r_det_rst_n;
    assign result_valid = (r_state == DONE);
    assign result_count = r_cnt;
    assign result_id    = r_id;

endmodule

// File: tb/tb_run_detect_sched.sv
// Randomized scoreboard bench for run_detect_sched with a behavioural
// 4-in-a-row detector; a CW=2 twin checks hit-count saturation.
module tb_run_detect_sched;

    localparam int WIDTH = 8;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       v0, v1, rr;
    logic [7:0] d0, d1;
    logic       ready0, ready1, b_ready0, b_ready1;
    logic       w_a, w_b, drn_a, drn_b, z_a, z_b;
    logic       rv_a, rv_b, id_a, id_b;
    logic [3:0] rc_a;
    logic [1:0] rc_b;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int         id;
        logic [7:0] word;
        int         acc;
    } exp_t;
    exp_t sbq[$];

    int         acc_cyc  = -1000;
    logic [7:0] acc_word = 8'h00;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    run_detect_sched #(.WIDTH(8), .CW(4)) dut_a (
        .clock(clock), .reset(rst_n),
        .req0_valid(v0), .req0_data(d0), .req0_ready(ready0),
        .req1_valid(v1), .req1_data(d1), .req1_ready(ready1),
        .w(w_a), .det_rst_n(drn_a), .z(z_a),
        .result_valid(rv_a), .result_count(rc_a), .result_id(id_a),
        .result_ready(rr)
    );

    run_detect_sched #(.WIDTH(8), .CW(2)) dut_b (
        .clock(clock), .reset(rst_n),
        .req0_valid(v0), .req0_data(d0), .req0_ready(b_ready0),
        .req1_valid(v1), .req1_data(d1), .req1_ready(b_ready1),
        .w(w_b), .det_rst_n(drn_b), .z(z_b),
        .result_valid(rv_b), .result_count(rc_b), .result_id(id_b),
        .result_ready(rr)
    );

    // External detectors: z high once the last four bits seen are equal
    int   run_a, run_b;
    logic last_a, last_b;

    always @(posedge clock or negedge drn_a) begin
        if (!drn_a) begin
            run_a  <= 0;
            last_a <= 1'b0;
        end else if (run_a == 0 || w_a != last_a) begin
            run_a  <= 1;
            last_a <= w_a;
        end else if (run_a < 4) begin
            run_a  <= run_a + 1;
        end
    end

    always @(posedge clock or negedge drn_b) begin
        if (!drn_b) begin
            run_b  <= 0;
            last_b <= 1'b0;
        end else if (run_b == 0 || w_b != last_b) begin
            run_b  <= 1;
            last_b <= w_b;
        end else if (run_b < 4) begin
            run_b  <= run_b + 1;
        end
    end

    assign z_a = (run_a == 4);
    assign z_b = (run_b == 4);

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Reference: number of 4-bit windows of equal bits, saturated
    function automatic int ref_hits(input logic [7:0] word, input int maxv);
        int n = 0;
        for (int j = 7; j >= 3; j--) begin
            if (word[j -: 4] == 4'hF || word[j -: 4] == 4'h0) n++;
        end
        return (n > maxv) ? maxv : n;
    endfunction

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 7))
            0:       return 8'hFF;
            1:       return 8'h00;
            2:       return 8'hAA;
            3:       return 8'hF0;
            4:       return 8'h0F;
            default: return 8'($urandom);
        endcase
    endfunction

    // Monitor: pops expectations when a result appears, checks the
    // serial wire during each word and the stability of held results
    initial begin : monitor
        bit   have;
        bit   rr_prev;
        int   hold;
        int   cur_cnt, cur_id, k, exp_n;
        exp_t e;
        have = 0;
        rr_prev = 0;
        hold = 0;
        cur_cnt = 0;
        cur_id = 0;
        rr = 1'b0;
        forever begin
            @(negedge clock);
            #2;
            if (!rst_n) begin
                have = 0;
                rr_prev = 0;
                rr = 1'b0;
                continue;
            end
            k = cyc - acc_cyc;
            if (k == 0) begin
                chk("clear_det_rst_n", int'(drn_a), 0);
                chk("clear_w", int'(w_a), 0);
            end else if (k >= 1 && k <= 8) begin
                chk("shift_w", int'(w_a), int'(acc_word[8-k]));
                chk("shift_det_rst_n", int'(drn_a), 1);
            end else if (k == 9) begin
                chk("drain_w", int'(w_a), 0);
            end
            if (rv_a) begin
                if (have && rr_prev) begin
                    chk("done_exit", int'(rv_a), 0);
                    have = 0;
                end
                if (!have) begin
                    if (sbq.size() == 0) begin
                        chk("spurious_result", int'(rv_a), 0);
                    end else begin
                        e = sbq.pop_front();
                        exp_n = ref_hits(e.word, 15);
                        chk("latency", cyc - e.acc, 10);
                        chk("result_count", int'(rc_a), exp_n);
                        chk("result_id", int'(id_a), e.id);
                        chk("sat_valid", int'(rv_b), 1);
                        chk("sat_count", int'(rc_b), ref_hits(e.word, 3));
                        chk("sat_id", int'(id_b), e.id);
                        cur_cnt = exp_n;
                        cur_id = e.id;
                        have = 1;
                        hold = ($urandom_range(0, 5) == 0)
                             ? 20 : int'($urandom_range(0, 2));
                    end
                end else begin
                    chk("held_count", int'(rc_a), cur_cnt);
                    chk("held_id", int'(id_a), cur_id);
                    chk("held_ready", int'(ready0 | ready1), 0);
                end
                if (hold == 0) rr = 1'b1;
                else begin
                    hold--;
                    rr = 1'b0;
                end
            end else begin
                have = 0;
                if (sbq.size() > 0 && cyc > sbq[0].acc + 10) begin
                    e = sbq.pop_front();
                    chk("result_timeout", cyc - e.acc, 10);
                end
                rr = 1'($urandom_range(0, 1));
            end
            rr_prev = rr;
        end
    end

    // Driver: requesters hold words until accepted; ties are checked
    // against the round-robin rule
    initial begin : driver
        bit take0, take1;
        int wt0, wt1, mode, g, last_served, a_edge, guard;
        take0 = 0;
        take1 = 0;
        wt0 = 0;
        wt1 = 0;
        last_served = 1;
        v0 = 1'b1;
        v1 = 1'b1;
        d0 = 8'h00;
        d1 = 8'h00;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_w", int'(w_a), 0);
        chk("rst_det_rst_n", int'(drn_a), 0);
        chk("rst_result_valid", int'(rv_a), 0);
        chk("rst_result_count", int'(rc_a), 0);
        chk("rst_result_id", int'(id_a), 0);
        chk("rst_ready0", int'(ready0), 0);
        chk("rst_ready1", int'(ready1), 0);
        v0 = 1'b0;
        v1 = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;

        for (int i = 0; i < 2400; i++) begin
            @(negedge clock);
            mode = (i / 300) % 3;
            if (take0) begin v0 = 1'b0; take0 = 0; wt0 = 0; end
            if (take1) begin v1 = 1'b0; take1 = 0; wt1 = 0; end
            if (!v0 && mode != 1
                && (mode == 0 || $urandom_range(0, 3) == 0)) begin
                v0 = 1'b1;
                d0 = pick();
            end
            if (!v1 && (mode != 2 || $urandom_range(0, 3) == 0)) begin
                v1 = 1'b1;
                d1 = pick();
            end
            #1;
            if ((v0 && ready0) || (v1 && ready1)) begin
                g = (v1 && ready1) ? 1 : 0;
                if (v0 && v1) chk("arb_tie", g, 1 - last_served);
                else          chk("arb_single", g, v1 ? 1 : 0);
                chk("ready_onehot", int'(ready0 & ready1), 0);
                chk("twin_ready", int'({b_ready0, b_ready1}),
                    int'({ready0, ready1}));
                last_served = g;
                acc_cyc = cyc + 1;
                acc_word = g ? d1 : d0;
                sbq.push_back('{id: g, word: acc_word, acc: cyc + 1});
                if (g == 1) take1 = 1;
                else        take0 = 1;
            end
            if (v0 && !take0) wt0++;
            if (v1 && !take1) wt1++;
            if (wt0 > 200) begin
                chk("req0_starved", wt0, 0);
                v0 = 1'b0;
                wt0 = 0;
            end
            if (wt1 > 200) begin
                chk("req1_starved", wt1, 0);
                v1 = 1'b0;
                wt1 = 0;
            end
        end
        @(negedge clock);
        v0 = 1'b0;
        v1 = 1'b0;
        guard = 0;
        while ((sbq.size() > 0 || rv_a) && guard < 300) begin
            @(negedge clock);
            guard++;
        end
        chk("drain_queue", sbq.size(), 0);

        // Reset in the middle of shifting a word: nothing may come out
        repeat (3) @(negedge clock);
        v0 = 1'b1;
        d0 = 8'hF0;
        #1;
        chk("rst_test_accept", int'(ready0), 1);
        a_edge = cyc + 1;
        acc_cyc = a_edge;
        acc_word = 8'hF0;
        @(negedge clock);
        v0 = 1'b0;
        while (cyc < a_edge + 4) @(negedge clock);
        v0 = 1'b1;
        rst_n = 1'b0;
        acc_cyc = -1000;
        #1;
        chk("mid_rst_w", int'(w_a), 0);
        chk("mid_rst_det_rst_n", int'(drn_a), 0);
        chk("mid_rst_valid", int'(rv_a), 0);
        chk("mid_rst_count", int'(rc_a), 0);
        chk("mid_rst_id", int'(id_a), 0);
        chk("mid_rst_ready0", int'(ready0), 0);
        v0 = 1'b0;
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clock);
            #1;
            chk("post_rst_no_result", int'(rv_a), 0);
        end
        @(negedge clock);
        v1 = 1'b1;
        d1 = 8'hF0;
        #1;
        chk("post_rst_accept", int'(ready1), 1);
        acc_cyc = cyc + 1;
        acc_word = 8'hF0;
        sbq.push_back('{id: 1, word: 8'hF0, acc: cyc + 1});
        @(negedge clock);
        v1 = 1'b0;
        guard = 0;
        while ((sbq.size() > 0 || rv_a) && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        chk("post_rst_result", sbq.size(), 0);
        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
